// File: rtl/unit_pulse_gen.sv
// Energy-to-unit pulse generator: accumulates power samples, emits one fixed-width sensor
// pulse per unit and queues excess units. Define UNIT_PULSE_FORCE_EN to add the force_unit input.
module unit_pulse_gen #(
  parameter int PWR_W           = 8,
  parameter int ENERGY_PER_UNIT = 1000,
  parameter int PULSE_HIGH      = 4,
  parameter int PULSE_LOW       = 4,
  parameter int BACKLOG_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [PWR_W-1:0]     power,
`ifdef UNIT_PULSE_FORCE_EN
  input  logic                 force_unit,
`endif
  output logic                 sensor,
  output logic [BACKLOG_W-1:0] pending,
  output logic                 overflow,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  localparam int ACC_W  = $clog2(ENERGY_PER_UNIT + 2**PWR_W);
  localparam int CNT_MX = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
  localparam int CNT_W  = $clog2(CNT_MX + 1);
  localparam int PEND_W = BACKLOG_W + 2;
  localparam logic [PEND_W-1:0] PEND_MAX = {2'b00, {BACKLOG_W{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 pulse_start;
  logic [ACC_W-1:0]     acc, acc_sum;
  logic                 unit_gen;
  logic [1:0]           unit_cnt;
  logic [PEND_W-1:0]    pend_sum;
  logic [BACKLOG_W-1:0] pending_nxt;
  logic                 unit_lost;

  assign state_dbg = state;

  // acc stays below ENERGY_PER_UNIT, so one sample yields at most one unit.
  always_comb begin
    acc_sum  = acc + ACC_W'(power);
    unit_gen = sample_valid && (acc_sum >= ACC_W'(ENERGY_PER_UNIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (sample_valid) begin
      acc <= unit_gen ? (acc_sum - ACC_W'(ENERGY_PER_UNIT)) : acc_sum;
    end
  end

  // Pulse FSM decides from registered pending, so a unit arriving while idle waits one cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pulse_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending != '0) begin
          state_nxt   = ST_HIGH;
          cnt_nxt     = CNT_W'(PULSE_HIGH - 1);
          pulse_start = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt == '0) begin
          state_nxt = ST_LOW;
          cnt_nxt   = CNT_W'(PULSE_LOW - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt == '0) begin
          if (pending != '0) begin
            state_nxt   = ST_HIGH;
            cnt_nxt     = CNT_W'(PULSE_HIGH - 1);
            pulse_start = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Backlog: add new units, remove a started one, clamp at full and flag anything lost.
  always_comb begin
`ifdef UNIT_PULSE_FORCE_EN
    unit_cnt = {1'b0, unit_gen} + {1'b0, force_unit};
`else
    unit_cnt = {1'b0, unit_gen};
`endif
    pend_sum = {2'b00, pending} + PEND_W'(unit_cnt) - PEND_W'(pulse_start);
    if (pend_sum > PEND_MAX) begin
      pending_nxt = PEND_MAX[BACKLOG_W-1:0];
      unit_lost   = 1'b1;
    end else begin
      pending_nxt = pend_sum[BACKLOG_W-1:0];
      unit_lost   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      sensor   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pending  <= pending_nxt;
      overflow <= overflow | unit_lost;
      sensor   <= (state_nxt == ST_HIGH);
      busy     <= (state_nxt != ST_IDLE) || (pending_nxt != '0);
    end
  end

endmodule

// File: doc/unit_pulse_gen.md
# unit_pulse_gen

Meter-front-end block that produces the `sensor` unit pulse train consumed by the unit-consumption counter. Accumulates per-cycle energy samples, emits one clean, width-controlled pulse per consumed unit, and queues units that arrive faster than pulses can be sent. It sits between the metering ADC/sample path and the consumption counter, all in one synchronous clock domain.

## Interface
Parameters:
- `PWR_W`, 8: width of the `power` sample.
- `ENERGY_PER_UNIT`, 1000: accumulated energy per unit. Must be greater than 2^PWR_W - 1, so one sample yields at most one unit.
- `PULSE_HIGH`, 4: cycles `sensor` stays high per unit, ≥1.
- `PULSE_LOW`, 4: minimum cycles `sensor` stays low after each pulse, ≥1.
- `BACKLOG_W`, 4: width of the pending-unit counter.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  `power` is valid this cycle.
- `power`  in  PWR_W  energy increment, unsigned.
- `sensor`  out  1  unit pulse to the consumption counter; registered.
- `pending`  out  BACKLOG_W  units accumulated but not yet emitted.
- `overflow`  out  1  sticky flag: a unit was dropped.
- `busy`  out  1  high when not in IDLE or when `pending` ≠ 0.

## Operation
- Accumulator `acc`: width clog2(ENERGY_PER_UNIT + 2^PWR_W).
  - When `sample_valid`=1: s = acc + power.
  - If s ≥ ENERGY_PER_UNIT: acc ← s − ENERGY_PER_UNIT and one unit is generated. Otherwise acc ← s.
  - When `sample_valid`=0: acc holds.
  - The remainder is always kept, never discarded.
- Backlog `pending`: +1 per generated unit, −1 when a pulse starts.
  - Both in the same cycle: net unchanged.
  - Generated unit while `pending` = 2^BACKLOG_W − 1 with no pulse starting: unit dropped, `pending` holds, `overflow` ← 1.
  - `overflow` clears only on reset.
- FSM with states IDLE, HIGH, LOW; counter `cnt`.
  - IDLE: `sensor`=0. If `pending` ≠ 0, go to HIGH, set cnt=PULSE_HIGH−1, consume one pending unit.
  - HIGH: `sensor`=1. Decrement cnt. At cnt=0, go to LOW and set cnt=PULSE_LOW−1.
  - LOW: `sensor`=0. Decrement cnt. At cnt=0, if `pending` ≠ 0 go directly to HIGH (consuming one unit), else go to IDLE.
- A unit generated in the same cycle the FSM is in IDLE with `pending`=0 is not eligible until the next cycle.
- Reset, asserted at any time including mid-pulse: acc=0, `pending`=0, `overflow`=0, state IDLE, `sensor`=0, `busy`=0 on the following edge. In-flight and queued units are discarded.

## Timing
- Threshold crossing sampled at edge N: `pending` increments at N. From IDLE, `sensor` rises at N+1.
- Each pulse: exactly PULSE_HIGH cycles high, then at least PULSE_LOW cycles low.
- Maximum sustained rate is one unit per PULSE_HIGH+PULSE_LOW cycles. Excess units are queued in `pending`.
- `sensor` is glitch-free and driven directly from a flop.
- `pending`, `overflow` and `busy` are registered and update on the same edge as the state change that causes them.

## Configuration
- `UNIT_PULSE_FORCE_EN`:
  - Defined: adds input `force_unit` (1 bit). A one-cycle assertion injects one unit into `pending` without touching acc. It obeys the same saturation and overflow rules.
  - If `force_unit` and a sample-generated unit occur in the same cycle, `pending` += 2, saturating; each lost unit sets `overflow`.
  - Not defined: the port is absent and the logic is not compiled.

## Test plan
- Reset: assert `reset` for 2 cycles with `power`=255 valid → `sensor`=0, `pending`=0, `overflow`=0, `busy`=0 throughout.
- Steady load, defaults: `power`=100 valid every cycle → crossing on the 10th sample, acc=0; `sensor` high for 4 cycles, then low 4; one pulse per 10 samples.
- Remainder: four samples of 255 → exactly one unit with acc=20; a further 4 × 245 → second unit with acc=0.
- Backlog and overflow: `power`=255 continuously (1 unit per ~4 cycles versus 8-cycle pulse period) → `pending` climbs to 15, `overflow` sets on the next unit, pulses continue back-to-back (HIGH 4 / LOW 4); stop samples → backlog drains to 0, then IDLE.
- Reset mid-pulse: assert `reset` in the 2nd HIGH cycle with `pending`=3 → `sensor`=0 and `pending`=0 at the next edge; no further pulses.
- With `UNIT_PULSE_FORCE_EN`: `force_unit` for 1 cycle, `sample_valid`=0 → one 4-cycle pulse, acc unchanged. `force_unit` coinciding with a crossing → `pending`=2, two pulses.
